// File: rtl/intel_vip_reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// intel_vip_reset_seq_pkg
// Shared types and helpers for the staged reset sequencer.
//   seq_state_t : sequencer FSM state encoding
//   idx_width() : width of a stage index, never narrower than one bit
// -----------------------------------------------------------------------------
package intel_vip_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_DELAY      = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_DONE       = 3'd3,
        ST_ERROR      = 3'd4
    } seq_state_t;

    // A single-stage build still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/intel_vip_reset_seq_timer.sv
// -----------------------------------------------------------------------------
// intel_vip_reset_seq_timer
// Up-counter shared by all timed phases of the reset sequencer.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (counter -> 0)
//   i_clr    in   synchronous clear, wins over i_en
//   i_en     in   count enable
//   i_limit  in   terminal value to match against (runtime selectable)
//   o_match  out  high while the count equals i_limit
// -----------------------------------------------------------------------------
module intel_vip_reset_seq_timer #(
    parameter int CNTR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [CNTR_WIDTH-1:0] i_limit,
    output logic                  o_match
);

    logic [CNTR_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNTR_WIDTH'(1);
        end
    end

    assign o_match = (r_cnt == i_limit);

endmodule

// File: rtl/intel_vip_reset_seq_block.sv
// -----------------------------------------------------------------------------
// intel_vip_reset_seq_block
// Releases NUM_STAGES subsystem resets in ascending order after the board
// reset deasserts. Each stage gets a settle delay before release and must then
// acknowledge within ACK_TIMEOUT cycles. A software request re-runs the whole
// sequence after a minimum hold period.
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset (pre-synchronised)
//   sw_reset_req   in   level request for a full re-sequence
//   stage_ready    in   per-stage "out of reset" acknowledge
//   stage_reset_n  out  active-low reset per stage
//   stage_reset    out  registered complement of stage_reset_n
//   seq_done       out  all stages released and acknowledged
//   timeout_err    out  sticky: a stage missed its acknowledge window
//   err_stage      out  index of the stage that timed out
// -----------------------------------------------------------------------------
module intel_vip_reset_seq_block
    import intel_vip_reset_seq_pkg::*;
#(
    parameter int  NUM_STAGES  = 4,
    parameter int  STAGE_DELAY = 16,
    parameter int  ACK_TIMEOUT = 1024,
    parameter int  HOLD_CYCLES = 32,
    parameter int  CNTR_WIDTH  = 16,
    localparam int IDX_W       = idx_width(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  seq_done,
    output logic                  timeout_err,
    output logic [IDX_W-1:0]      err_stage
);

    localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

    seq_state_t              r_state;
    seq_state_t              w_state_nxt;
    logic [IDX_W-1:0]        r_k;
    logic [IDX_W-1:0]        w_k_nxt;
    logic [NUM_STAGES-1:0]   r_rst_n;
    logic [NUM_STAGES-1:0]   w_rst_n_nxt;
    logic [NUM_STAGES-1:0]   r_rst;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_terr;
    logic                    w_terr_nxt;
    logic [IDX_W-1:0]        r_err_stage;
    logic [IDX_W-1:0]        w_err_stage_nxt;

    logic                    w_cnt_clr;
    logic                    w_cnt_en;
    logic [CNTR_WIDTH-1:0]   w_limit;
    logic                    w_match;

    // One counter serves every timed phase; its terminal value follows the
    // current state so the match output always means "this phase is over".
    always_comb begin
        w_limit = '0;
        case (r_state)
            ST_HOLD:       w_limit = CNTR_WIDTH'(HOLD_CYCLES - 1);
            ST_DELAY:      w_limit = CNTR_WIDTH'(STAGE_DELAY - 1);
            ST_WAIT_READY: w_limit = CNTR_WIDTH'(ACK_TIMEOUT - 1);
            default:       w_limit = '0;
        endcase
    end

    intel_vip_reset_seq_timer #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (w_limit),
        .o_match (w_match)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_rst_n_nxt     = r_rst_n;
        w_done_nxt      = r_done;
        w_terr_nxt      = r_terr;
        w_err_stage_nxt = r_err_stage;
        w_cnt_clr       = 1'b0;
        w_cnt_en        = 1'b0;

        if (sw_reset_req) begin
            // Software request overrides anything else happening this edge;
            // holding the counter clear keeps the hold period measured from
            // the moment the request drops.
            w_state_nxt     = ST_HOLD;
            w_k_nxt         = '0;
            w_rst_n_nxt     = '0;
            w_done_nxt      = 1'b0;
            w_terr_nxt      = 1'b0;
            w_err_stage_nxt = '0;
            w_cnt_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_match) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_DELAY;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end

                ST_DELAY: begin
                    if (w_match) begin
                        w_rst_n_nxt[r_k] = 1'b1;
                        w_cnt_clr        = 1'b1;
                        w_state_nxt      = ST_WAIT_READY;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end

                // Ready is only looked at here, so an acknowledge already
                // high on the release edge is not taken until the next edge.
                ST_WAIT_READY: begin
                    if (stage_ready[r_k]) begin
                        w_cnt_clr = 1'b1;
                        if (r_k == LAST_STAGE) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_k_nxt     = r_k + IDX_W'(1);
                            w_state_nxt = ST_DELAY;
                        end
                    end else if (w_match) begin
                        w_terr_nxt      = 1'b1;
                        w_err_stage_nxt = r_k;
                        w_state_nxt     = ST_ERROR;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end

                // Terminal until software asks again.
                ST_DONE, ST_ERROR: begin
                    w_state_nxt = r_state;
                end

                default: begin
                    w_state_nxt = ST_DELAY;
                    w_k_nxt     = '0;
                    w_cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_DELAY;
            r_k         <= '0;
            r_rst_n     <= '0;
            r_rst       <= '1;
            r_done      <= 1'b0;
            r_terr      <= 1'b0;
            r_err_stage <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_rst_n     <= w_rst_n_nxt;
            r_rst       <= ~w_rst_n_nxt;
            r_done      <= w_done_nxt;
            r_terr      <= w_terr_nxt;
            r_err_stage <= w_err_stage_nxt;
        end
    end

    assign stage_reset_n = r_rst_n;
    assign stage_reset   = r_rst;
    assign seq_done      = r_done;
    assign timeout_err   = r_terr;
    assign err_stage     = r_err_stage;

endmodule

// File: tb/tb_intel_vip_reset_seq_block.sv
// -----------------------------------------------------------------------------
// tb_intel_vip_reset_seq_block
// Directed bench for the staged reset sequencer at default parameters.
// -----------------------------------------------------------------------------
module tb_intel_vip_reset_seq_block;

    localparam int N = 4;

    logic         clk          = 1'b0;
    logic         reset_n      = 1'b0;
    logic         sw_reset_req = 1'b0;
    logic [N-1:0] stage_ready  = '0;
    logic [N-1:0] stage_reset_n;
    logic [N-1:0] stage_reset;
    logic         seq_done;
    logic         timeout_err;
    logic [1:0]   err_stage;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    intel_vip_reset_seq_block dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sw_reset_req  (sw_reset_req),
        .stage_ready   (stage_ready),
        .stage_reset_n (stage_reset_n),
        .stage_reset   (stage_reset),
        .seq_done      (seq_done),
        .timeout_err   (timeout_err),
        .err_stage     (err_stage)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rst(input string tag, input logic [N-1:0] mask);
        logic [N-1:0] inv;
        inv = ~mask;
        expect_eq({tag, "_rstn"}, 32'(stage_reset_n), 32'(mask));
        expect_eq({tag, "_rst"},  32'(stage_reset),   32'(inv));
    endtask

    initial begin
        logic [N-1:0] m_pre;
        logic [N-1:0] m_rel;
        int           edge_no;

        // Reset state while reset_n is held low
        tick(3);
        expect_rst("rst", 4'b0000);
        expect_eq("rst_done", 32'(seq_done), 32'd0);
        expect_eq("rst_terr", 32'(timeout_err), 32'd0);
        expect_eq("rst_estg", 32'(err_stage), 32'd0);

        // Test 1: release at edge 0, ready 3 cycles after each release.
        // Releases expected at edges 16, 36, 56, 76; done at edge 80.
        reset_n = 1'b1;
        edge_no = 0;
        for (int k = 0; k < N; k++) begin
            int rel;
            rel   = 16 + 20 * k;
            m_pre = 4'((1 << k) - 1);
            m_rel = 4'((1 << (k + 1)) - 1);
            tick(rel - 1 - edge_no);
            edge_no = rel - 1;
            expect_rst($sformatf("t1_pre%0d", k), m_pre);
            tick(1);
            edge_no = rel;
            expect_rst($sformatf("t1_rel%0d", k), m_rel);
            tick(3);
            edge_no = rel + 3;
            stage_ready[k] = 1'b1;
        end
        expect_eq("t1_done79", 32'(seq_done), 32'd0);
        tick(1);
        expect_eq("t1_done80", 32'(seq_done), 32'd1);
        expect_rst("t1_all", 4'b1111);

        // Test 4 (from DONE): request for 10 edges, re-release 48 edges later
        stage_ready  = '0;
        sw_reset_req = 1'b1;
        tick(1);
        expect_rst("t4_req", 4'b0000);
        expect_eq("t4_done", 32'(seq_done), 32'd0);
        tick(9);
        sw_reset_req = 1'b0;
        stage_ready  = 4'b1111;     // test 2: ready already high before release
        tick(47);
        expect_rst("t4_pre", 4'b0000);
        tick(1);
        expect_rst("t4_rel", 4'b0001);

        // Test 2: ready on the release edge ignored, next stage 17 edges later
        for (int k = 1; k < N; k++) begin
            m_pre = 4'((1 << k) - 1);
            m_rel = 4'((1 << (k + 1)) - 1);
            tick(16);
            expect_rst($sformatf("t2_pre%0d", k), m_pre);
            tick(1);
            expect_rst($sformatf("t2_rel%0d", k), m_rel);
        end

        // Test 6: request on the edge stage 3 would be acknowledged
        sw_reset_req = 1'b1;
        tick(1);
        expect_eq("t6_done", 32'(seq_done), 32'd0);
        expect_rst("t6_req", 4'b0000);
        sw_reset_req = 1'b0;
        stage_ready  = 4'b0011;
        tick(47);
        expect_rst("t6_hold", 4'b0000);
        tick(1);
        expect_rst("t6_rel", 4'b0001);

        // Test 3: stage 2 never acknowledges
        tick(34);
        expect_rst("t3_rel2", 4'b0111);
        tick(1023);
        expect_eq("t3_terr_pre", 32'(timeout_err), 32'd0);
        tick(1);
        expect_eq("t3_terr", 32'(timeout_err), 32'd1);
        expect_eq("t3_estg", 32'(err_stage), 32'd2);
        expect_eq("t3_done", 32'(seq_done), 32'd0);
        expect_rst("t3_err", 4'b0111);
        stage_ready = 4'b1111;
        tick(5000);
        expect_eq("t3_terr_hold", 32'(timeout_err), 32'd1);
        expect_eq("t3_estg_hold", 32'(err_stage), 32'd2);
        expect_eq("t3_done_hold", 32'(seq_done), 32'd0);
        expect_rst("t3_hold", 4'b0111);

        // Test 4 (from ERROR): request clears the error
        sw_reset_req = 1'b1;
        tick(1);
        expect_eq("t4e_terr", 32'(timeout_err), 32'd0);
        expect_eq("t4e_estg", 32'(err_stage), 32'd0);
        expect_rst("t4e_req", 4'b0000);
        sw_reset_req = 1'b0;
        stage_ready  = '0;
        tick(47);
        expect_rst("t4e_pre", 4'b0000);
        tick(1);
        expect_rst("t4e_rel", 4'b0001);
        tick(3);
        stage_ready[0] = 1'b1;
        tick(17);
        expect_rst("t5_rel1", 4'b0011);
        tick(5);

        // Test 5: asynchronous reset mid WAIT_READY of stage 1
        #2;
        reset_n = 1'b0;
        #1;
        expect_rst("t5_async", 4'b0000);
        expect_eq("t5_done", 32'(seq_done), 32'd0);
        expect_eq("t5_terr", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        tick(15);
        expect_rst("t5_pre", 4'b0000);
        tick(1);
        expect_rst("t5_rel", 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
